sd_dat_engine: RTL
==================

# sd_dat_engine

Parametrised SD data-line engine that transfers one data block over the SD DAT lines. It is the successor to the fixed 4-bit D-line driver in the SD transceiver. It supports 1-bit or 4-bit bus width, a configurable block size, per-lane CRC16 generation and checking, write CRC-status/busy handling, and read/busy timeouts. It sits beside the CMD driver and exchanges whole cipher blocks with the GOST datapath.

## Interface
- LANES, 4, active DAT lanes; legal values 1 or 4.
- BLOCK_BITS, 128, bits per block; must be a multiple of LANES.
- RX_TIMEOUT, 4096, SD clock cycles to wait for a read start bit.
- BUSY_TIMEOUT, 65535, SD clock cycles to wait for end of write busy.
- iclk  in  1  SD bus clock; all logic on its rising edge.
- irst  in  1  asynchronous, active-high reset.
- isend  in  1  start a write-block transfer (sampled only in IDLE).
- ircv  in  1  start a read-block transfer (sampled only in IDLE).
- iblock  in  BLOCK_BITS  block to write; captured on the accepted isend.
- idata_sd  in  4  sampled DAT[3:0]; unused lanes ignored.
- odata_sd  out  4  driven DAT[3:0] value.
- odata_oe  out  4  per-lane output enable; unused lanes always 0.
- oblock  out  BLOCK_BITS  received block; valid from the odone pulse of a read until the next accepted start.
- obusy  out  1  high whenever the state is not IDLE.
- odone  out  1  one-cycle pulse marking the end of any transfer, successful or not.
- ocrc_fail  out  1  read CRC mismatch, bad end bit, or write status not 010; held until the next accepted start.
- otimeout  out  1  RX or busy timeout; held until the next accepted start.

## Operation
- States: IDLE, TX_START, TX_DATA, TX_CRC, TX_END, TX_STAT, TX_BUSY, RX_WAIT, RX_DATA, RX_CRC, RX_END, DONE.
- IDLE: if isend, capture iblock and go to TX_START. Else if ircv, go to RX_WAIT. If both are high, isend wins. Starts in any other state are ignored.
- Lane mapping: each cycle carries LANES bits MSB-first. With LANES=4, bit 3 of the nibble goes on DAT3 and bit 0 on DAT0.
- DATA phase length is N = BLOCK_BITS/LANES cycles.
- CRC: one CRC16 per lane, polynomial x^16+x^12+x^5+1, init 0x0000, covering that lane's data bits only (not start or end bits). CRC is sent and received MSB first.
- TX_START drives 0 on active lanes for 1 cycle. TX_DATA lasts N cycles, TX_CRC 16 cycles, and TX_END drives 1 for 1 cycle.
- After TX_END, odata_oe is 0 on all lanes.
- TX_STAT on D0:
  - Wait for a 0 start bit (at most 8 cycles, otherwise otimeout).
  - Shift in 3 status bits.
  - Skip 1 end bit.
  - Status 010 means OK; any other value sets ocrc_fail.
- TX_BUSY: wait while D0=0. When D0=1, go to DONE. After BUSY_TIMEOUT cycles with D0 still 0, set otimeout and go to DONE.
- RX_WAIT: wait for D0=0. If it has not arrived after RX_TIMEOUT cycles, set otimeout and go to DONE.
- RX_DATA lasts N cycles. RX_CRC shifts in 16 bits per lane and compares them with the computed CRC.
- RX_END: any active lane not 1 sets ocrc_fail.
- DONE: assert odone for 1 cycle, then return to IDLE.
- Counter width is $clog2(max(N, 16, RX_TIMEOUT, BUSY_TIMEOUT)+1). Counters saturate and never wrap.

## Timing
- Reset values (applied asynchronously): state IDLE, odata_sd=4'hF, odata_oe=0, oblock=0, obusy=0, odone=0, ocrc_fail=0, otimeout=0, CRC registers 0.
- All outputs are registered.
- Write: isend is accepted at edge k. The start bit appears on odata_sd/odata_oe after edge k+1, and obusy rises after edge k+1.
- odata_oe stays high for exactly 1+N+16+1 cycles: 50 for LANES=4/128 bits, 146 for LANES=1/128 bits.
- Read: the first data bit is sampled on the edge after the start bit is sampled.
- odone rises 1 cycle after the end-bit or last-busy sample.
- ocrc_fail, otimeout and oblock update no later than the edge on which odone rises.
- Reset asserted mid-transfer: odata_oe drops immediately (asynchronously). No odone is issued.

## Test plan
- LANES=4, write iblock=0. Response: status 010, then D0 low 5 cycles.
  - Expect 50 driven cycles, all data and CRC bits 0, end bit F.
  - Expect odone once; ocrc_fail=0, otimeout=0.
- LANES=4, read 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with CRCs from the bench model.
  - Expect oblock equal to the pattern, odone, and ocrc_fail=0.
- Same read with one DAT2 CRC bit flipped.
  - Expect ocrc_fail=1 and odone.
- Write with status token 101.
  - Expect ocrc_fail=1 and odone after busy release.
- Read with D0 held high for RX_TIMEOUT=16 cycles.
  - Expect otimeout=1 and odone 1 cycle after cycle 16.
- LANES=1, write, with irst pulsed at data cycle 40.
  - Expect odata_oe=0 and obusy=0 immediately, no odone.
  - A subsequent isend gives a clean 146-cycle frame.

Source files
------------

// File: rtl/sd_dat_engine.sv
// sd_dat_engine
//
// Moves one data block across the SD DAT lines, either host-to-card (write) or
// card-to-host (read). Supports 1-bit or 4-bit bus width and keeps one CRC16 per
// active lane. Write transfers also collect the card's CRC-status token and wait
// out its busy indication. Read transfers and busy waits are bounded by timeouts.
//
// Every output is a register. The drive outputs (odata_sd/odata_oe) are computed
// from the current state, so they trail the state register by one cycle.
//
// Ports
//   iclk       SD bus clock, rising edge
//   irst       asynchronous active-high reset
//   isend      start a block write (IDLE only, wins over ircv)
//   ircv       start a block read (IDLE only)
//   iblock     block to write, captured when isend is accepted
//   idata_sd   sampled DAT[3:0]
//   odata_sd   driven DAT[3:0]
//   odata_oe   per-lane output enable
//   oblock     last received block
//   obusy      transfer in progress
//   odone      one-cycle end-of-transfer pulse
//   ocrc_fail  read CRC/end-bit error or bad write status token
//   otimeout   read start-bit, status or busy timeout
module sd_dat_engine #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned BLOCK_BITS   = 128,
    parameter int unsigned RX_TIMEOUT   = 4096,
    parameter int unsigned BUSY_TIMEOUT = 65535
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  isend,
    input  logic                  ircv,
    input  logic [BLOCK_BITS-1:0] iblock,
    input  logic [3:0]            idata_sd,
    output logic [3:0]            odata_sd,
    output logic [3:0]            odata_oe,
    output logic [BLOCK_BITS-1:0] oblock,
    output logic                  obusy,
    output logic                  odone,
    output logic                  ocrc_fail,
    output logic                  otimeout
);

    // Number of bus cycles in the data phase
    localparam int unsigned N = BLOCK_BITS / LANES;

    // Counter must hold the largest phase length or timeout
    localparam int unsigned MAX_A   = (N > 16) ? N : 16;
    localparam int unsigned MAX_B   = (RX_TIMEOUT > BUSY_TIMEOUT) ? RX_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] DATA_LAST      = CW'(N - 1);
    localparam logic [CW-1:0] CRC_LAST       = CW'(15);
    localparam logic [CW-1:0] RX_LAST        = CW'(RX_TIMEOUT - 1);
    localparam logic [CW-1:0] BUSY_LAST      = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] STAT_WAIT_LAST = CW'(7);
    localparam logic [CW-1:0] STAT_BITS      = CW'(3);

    localparam logic [3:0] LANE_MASK = (LANES == 4) ? 4'hF : 4'h1;
    localparam logic [2:0] STAT_OK   = 3'b010;

    // FSM encoding
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] TX_START = 4'd1;
    localparam logic [3:0] TX_DATA  = 4'd2;
    localparam logic [3:0] TX_CRC   = 4'd3;
    localparam logic [3:0] TX_END   = 4'd4;
    localparam logic [3:0] TX_STAT  = 4'd5;
    localparam logic [3:0] TX_BUSY  = 4'd6;
    localparam logic [3:0] RX_WAIT  = 4'd7;
    localparam logic [3:0] RX_DATA  = 4'd8;
    localparam logic [3:0] RX_CRC   = 4'd9;
    localparam logic [3:0] RX_END   = 4'd10;
    localparam logic [3:0] DONE     = 4'd11;

    // One serial CRC16 step, polynomial x^16+x^12+x^5+1
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    logic [3:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0]       shreg_q, shreg_d;
    logic [LANES-1:0][15:0]      crc_q, crc_d;
    logic                        stat_go_q, stat_go_d;
    logic [2:0]                  stat_q, stat_d;

    logic [3:0]                  sd_d;
    logic [3:0]                  oe_d;
    logic [BLOCK_BITS-1:0]       oblock_d;
    logic                        busy_d;
    logic                        done_d;
    logic                        fail_d;
    logic                        timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        crc_d     = crc_q;
        stat_go_d = stat_go_q;
        stat_d    = stat_q;
        sd_d      = 4'hF;
        oe_d      = 4'h0;
        oblock_d  = oblock;
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == DONE);
        fail_d    = ocrc_fail;
        timeout_d = otimeout;

        case (state_q)
            IDLE: begin
                if (isend || ircv) begin
                    cnt_d     = '0;
                    crc_d     = '0;
                    stat_go_d = 1'b0;
                    stat_d    = '0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
                if (isend) begin
                    shreg_d = iblock;
                    state_d = TX_START;
                end else if (ircv) begin
                    state_d = RX_WAIT;
                end
            end

            TX_START: begin
                sd_d    = 4'hF & ~LANE_MASK;
                oe_d    = LANE_MASK;
                cnt_d   = '0;
                state_d = TX_DATA;
            end

            TX_DATA: begin
                oe_d = LANE_MASK;
                // Top LANES bits of the shift register, MSB on the highest lane
                for (int l = 0; l < LANES; l++) begin
                    sd_d[l]  = shreg_q[BLOCK_BITS - LANES + l];
                    crc_d[l] = crc_step(crc_q[l], shreg_q[BLOCK_BITS - LANES + l]);
                end
                shreg_d = {shreg_q[BLOCK_BITS-LANES-1:0], {LANES{1'b0}}};
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_CRC;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            TX_CRC: begin
                oe_d = LANE_MASK;
                // CRC goes out MSB first by shifting the lane registers
                for (int l = 0; l < LANES; l++) begin
                    sd_d[l]  = crc_q[l][15];
                    crc_d[l] = {crc_q[l][14:0], 1'b0};
                end
                if (cnt_q == CRC_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_END;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            TX_END: begin
                oe_d    = LANE_MASK;
                cnt_d   = '0;
                state_d = TX_STAT;
            end

            TX_STAT: begin
                if (!stat_go_q) begin
                    // Hunting for the status start bit on D0
                    if (!idata_sd[0]) begin
                        stat_go_d = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt_q == STAT_WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d = inc_sat(cnt_q);
                    end
                end else if (cnt_q != STAT_BITS) begin
                    stat_d = {stat_q[1:0], idata_sd[0]};
                    cnt_d  = inc_sat(cnt_q);
                end else begin
                    // Status end bit: its value is not checked
                    if (stat_q != STAT_OK) begin
                        fail_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = TX_BUSY;
                end
            end

            TX_BUSY: begin
                if (idata_sd[0]) begin
                    state_d = DONE;
                end else if (cnt_q == BUSY_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            RX_WAIT: begin
                if (!idata_sd[0]) begin
                    cnt_d   = '0;
                    state_d = RX_DATA;
                end else if (cnt_q == RX_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            RX_DATA: begin
                for (int l = 0; l < LANES; l++) begin
                    crc_d[l] = crc_step(crc_q[l], idata_sd[l]);
                end
                shreg_d = {shreg_q[BLOCK_BITS-LANES-1:0], idata_sd[LANES-1:0]};
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_CRC;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            RX_CRC: begin
                // Compare each received CRC bit against the computed MSB
                for (int l = 0; l < LANES; l++) begin
                    if (idata_sd[l] != crc_q[l][15]) begin
                        fail_d = 1'b1;
                    end
                    crc_d[l] = {crc_q[l][14:0], 1'b0};
                end
                if (cnt_q == CRC_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_END;
                end else begin
                    cnt_d = inc_sat(cnt_q);
                end
            end

            RX_END: begin
                if (idata_sd[LANES-1:0] != {LANES{1'b1}}) begin
                    fail_d = 1'b1;
                end
                oblock_d = shreg_q;
                state_d  = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            crc_q     <= '0;
            stat_go_q <= 1'b0;
            stat_q    <= '0;
            odata_sd  <= 4'hF;
            odata_oe  <= 4'h0;
            oblock    <= '0;
            obusy     <= 1'b0;
            odone     <= 1'b0;
            ocrc_fail <= 1'b0;
            otimeout  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            crc_q     <= crc_d;
            stat_go_q <= stat_go_d;
            stat_q    <= stat_d;
            odata_sd  <= sd_d;
            odata_oe  <= oe_d;
            oblock    <= oblock_d;
            obusy     <= busy_d;
            odone     <= done_d;
            ocrc_fail <= fail_d;
            otimeout  <= timeout_d;
        end
    end

endmodule
